lc3_addr_gen: RTL
=================

// Module: lc3_addr_gen
// PURPOSE
//  Parametrised, pipelined LC-3 effective-address generator.
//  - Computes base (PC or SR1) + sign-extended IR offset (0, [5:0], [8:0], [10:0]).
//  - Issues either one address or a burst of sequential addresses, such as for TRAP PUTS or block moves.
//  - Uses valid/ready handshakes on both sides. Sits between decode/regfile and the memory-access sequencer.
// PARAMETERS
//  ADDR_W  16  address/data width; all arithmetic is modulo 2**ADDR_W
//  CNT_W    8  width of burst length / beat counter
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        synchronous, active-high
//  req_valid  in   1        request present
//  req_ready  out  1        block can accept request this cycle
//  addr1_mux  in   1        0=PC base, 1=SR1 base
//  addr2_mux  in   2        00=0, 01=sext(ir[5:0]), 10=sext(ir[8:0]), 11=sext(ir[10:0])
//  ir         in   16       instruction register
//  pc         in   ADDR_W   program counter
//  sr1out     in   ADDR_W   SR1 register value
//  burst_len  in   CNT_W    beats requested; 0 and 1 both mean single beat
//  priv       in   1        1=user mode (used only with LC3_AGU_ACV_EN)
//  out_valid  out  1        addr_out valid
//  out_ready  in   1        consumer accepts beat
//  addr_out   out  ADDR_W   generated address (registered)
//  out_last   out  1        current beat is final of the request
//  out_acv    out  1        access-control violation on current beat
//  busy       out  1        request in flight (out_valid held or beats remaining)
// BEHAVIOUR
//  - Reset (sync): out_valid=0, addr_out=0, out_last=0, out_acv=0, busy=0, remaining=0, state IDLE.
//  - Sign extension uses the true MSB of each field: ir[5], ir[8] and ir[10] respectively.
//  - States:
//    - IDLE: nothing held.
//    - ISSUE: out_valid=1 and beats remain.
//  - req_ready = ~out_valid | (out_ready & out_last). Back-to-back accept is allowed in the last-beat handshake cycle.
//  - Accept (req_valid & req_ready):
//    - Next cycle: addr_out = base + offset, out_valid=1, state ISSUE.
//    - remaining = max(burst_len,1) - 1; out_last = (remaining==0).
//    - Latency: 1 cycle from accept to first beat.
//  - Beat handshake (out_valid & out_ready):
//    - If out_last: out_valid drops to 0 (unless a new request is accepted the same cycle) and state goes to IDLE.
//    - Otherwise: addr_out += 1 (wraps xFFFF->x0000), remaining -= 1, out_last = (remaining-1==0).
//  - Stall (out_valid & ~out_ready): addr_out, out_last and out_acv hold stable; request inputs are ignored.
//  - Request inputs are sampled only on accept; later changes have no effect on an in-flight burst.
//  - busy = out_valid.
//  - Reset mid-burst: the burst is abandoned; all outputs return to reset values on the next edge.
// CONFIGURATION
//  Macro LC3_AGU_ACV_EN.
//  - Defined: out_acv is registered with each beat, = priv & (addr < x3000 | addr >= xFE00), bounds from package.
//    - A beat with out_acv=1 also forces out_last=1; the burst terminates after that handshake.
//  - Undefined: out_acv is tied 0, priv is ignored, and bursts always run to full length.
// STRUCTURE
//  - Package lc3_pkg:
//    - ADDR2 select encodings (ADDR2_ZERO/OFF6/OFF9/OFF11).
//    - USER_SPACE_LO=16'h3000 and DEV_SPACE_LO=16'hFE00.
//    - State encoding (S_IDLE, S_ISSUE).
//  - One combinational sub-module lc3_offset_sext (ir, addr2_mux -> ADDR_W offset).
//  - Base mux, adder, counter and FSM live in the top module.
// TESTING
//  1. Reset held 2 cycles mid-stream -> out_valid=0, addr_out=0, busy=0, req_ready=1 on next cycle.
//  2. pc=x3000, addr1_mux=0, addr2_mux=10, ir[8:0]=x1FF, burst_len=1 -> one cycle later addr_out=x2FFF, out_last=1.
//  3. sr1out=xFFFE, addr2_mux=00, burst_len=4, out_ready toggled 1,0,1,1,1.
//     -> beats xFFFE, xFFFF (held 2 cycles), x0000, x0001; out_last only on x0001.
//  4. Second request (pc=x4000, addr2_mux=01, ir[5:0]=x3F) valid during last-beat handshake.
//     -> accepted the same cycle; addr_out=x3FFF next cycle with no idle bubble.
//  5. ACV_EN, priv=1, sr1out=xFDFE, burst_len=4.
//     -> beats xFDFE and xFDFF with acv=0; xFE00 with out_acv=1 and out_last=1; burst ends.
//     Without the macro: 4 beats, acv=0.
//  6. Request inputs changed every cycle during a 3-beat burst -> beats unaffected; req_ready=0 until last handshake.

Source files
------------

// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// lc3_pkg : shared encodings and memory-map bounds for the LC-3 address unit
// Rev 1.0 : initial release
// ============================================================================
package lc3_pkg;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [15:0] USER_SPACE_LO = 16'h3000;
  localparam logic [15:0] DEV_SPACE_LO  = 16'hFE00;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lc3_offset_sext.sv
`default_nettype none
// ============================================================================
// lc3_offset_sext : selects and sign-extends the IR offset field for ADDR2
// Rev 1.0 : initial release
// ============================================================================
module lc3_offset_sext
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [15:0]       ir,
  input  logic [1:0]        addr2_mux,
  output logic [ADDR_W-1:0] offset
);

  // Opcode bits never feed an offset field.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir[15:11];

  always_comb begin
    offset = '0;
    case (addr2_mux)
      ADDR2_ZERO:  offset = '0;
      ADDR2_OFF6:  offset = {{(ADDR_W-6){ir[5]}},   ir[5:0]};
      ADDR2_OFF9:  offset = {{(ADDR_W-9){ir[8]}},   ir[8:0]};
      ADDR2_OFF11: offset = {{(ADDR_W-11){ir[10]}}, ir[10:0]};
      default:     offset = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lc3_addr_gen.sv
`default_nettype none
// ============================================================================
// lc3_addr_gen : pipelined LC-3 effective-address / burst generator
// Rev 1.0 : initial release; optional access checking via LC3_AGU_ACV_EN
// ============================================================================
module lc3_addr_gen
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              addr1_mux,
  input  logic [1:0]        addr2_mux,
  input  logic [15:0]       ir,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] sr1out,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              priv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              out_last,
  output logic              out_acv,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  remaining, rem_nxt, first_rem;
  logic [ADDR_W-1:0] addr_nxt, offset, base, ea, addr_inc;
  logic              last_nxt, acv_nxt, accept, beat_hs;
  logic              acv_accept, acv_step;

  lc3_offset_sext #(.ADDR_W(ADDR_W)) u_sext (
    .ir        (ir),
    .addr2_mux (addr2_mux),
    .offset    (offset)
  );

  assign out_valid = (state == S_ISSUE);
  assign busy      = out_valid;
  assign req_ready = ~out_valid | (out_ready & out_last);
  assign accept    = req_valid & req_ready;
  assign beat_hs   = out_valid & out_ready;

  assign base      = addr1_mux ? sr1out : pc;
  assign ea        = base + offset;
  assign addr_inc  = addr_out + ADDR_W'(1);
  assign first_rem = (burst_len == '0) ? '0 : burst_len - CNT_W'(1);

`ifdef LC3_AGU_ACV_EN
  // Privilege is captured at accept so the whole burst is judged by the requester.
  logic priv_q;
  always_ff @(posedge clk) begin
    if (reset)       priv_q <= 1'b0;
    else if (accept) priv_q <= priv;
  end
  assign acv_accept = priv & ((ea < ADDR_W'(USER_SPACE_LO)) | (ea >= ADDR_W'(DEV_SPACE_LO)));
  assign acv_step   = priv_q & ((addr_inc < ADDR_W'(USER_SPACE_LO)) |
                                (addr_inc >= ADDR_W'(DEV_SPACE_LO)));
`else
  logic unused_priv;
  assign unused_priv = priv;
  assign acv_accept  = 1'b0;
  assign acv_step    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_out;
    rem_nxt   = remaining;
    last_nxt  = out_last;
    acv_nxt   = out_acv;
    // accept is only possible when idle or on the last-beat handshake.
    if (accept) begin
      state_nxt = S_ISSUE;
      addr_nxt  = ea;
      rem_nxt   = first_rem;
      last_nxt  = (first_rem == '0) | acv_accept;
      acv_nxt   = acv_accept;
    end else if (beat_hs) begin
      if (out_last) begin
        state_nxt = S_IDLE;
      end else begin
        addr_nxt = addr_inc;
        rem_nxt  = remaining - CNT_W'(1);
        last_nxt = (remaining == CNT_W'(1)) | acv_step;
        acv_nxt  = acv_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_out  <= '0;
      remaining <= '0;
      out_last  <= 1'b0;
      out_acv   <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_out  <= addr_nxt;
      remaining <= rem_nxt;
      out_last  <= last_nxt;
      out_acv   <= acv_nxt;
    end
  end

endmodule
`default_nettype wire
